// File: rtl/prbs_ddr_checker.sv
// Receive-side checker for the IDDR/ODDR loopback: bit-slips a local replica of the three-ring
// source (255/256/257) into alignment and reports lock and errors. Optional: PRBS_DDR_CHECKER_FIRST_ERR_EN.
module prbs_ddr_checker #(
    parameter logic [254:0] SEED1 = 255'({64'h9E3779B97F4A7C15, 64'hBF58476D1CE4E5B9,
                                          64'h94D049BB133111EB, 64'hD6E8FEB86659FD93}),
    parameter logic [255:0] SEED2 = 256'({64'hA0761D6478BD642F, 64'hE7037ED1A0B428DB,
                                          64'h8EBC6AF09C88C6E3, 64'h589965CC75374CC3}),
    parameter logic [256:0] SEED3 = 257'({1'b1, 64'h1D8E4E27C47D124F, 64'hC2B2AE3D27D4EB4F,
                                          64'h165667B19E3779F9, 64'h27D4EB2F165667C5}),
    parameter int LOCK_LEN    = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int MAX_SLIP    = 64,
    parameter int ERR_W       = 16,
    localparam int SLIP_W     = $clog2(MAX_SLIP + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic              D1,
    input  logic              D2,
    output logic              LOCKED,
    output logic              ERROR,
    output logic [ERR_W-1:0]  ERR_COUNT,
    output logic [SLIP_W-1:0] SLIP_COUNT,
    output logic              TIMEOUT
`ifdef PRBS_DDR_CHECKER_FIRST_ERR_EN
    ,
    output logic [31:0]       FIRST_ERR_POS,
    output logic              FIRST_ERR_VLD
`endif
);

    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED, ST_FAIL} state_t;

    localparam int RUN_W = $clog2(LOCK_LEN + 1);
    localparam int STK_W = $clog2(UNLOCK_ERRS + 1);

    state_t            state_q, state_d;
    logic [254:0]      ring1;
    logic [255:0]      ring2;
    logic [256:0]      ring3;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [STK_W-1:0]  streak_q, streak_d;
    logic [SLIP_W-1:0] slip_d;
    logic [ERR_W-1:0]  errc_d;
    logic              error_d, rotate, slip, match;

    assign match = (D1 == (ring1[0] ^ ring2[0])) && (D2 == (ring2[0] ^ ring3[0]));

    // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        streak_d = streak_q;
        slip_d   = SLIP_COUNT;
        errc_d   = ERR_COUNT;
        error_d  = 1'b0;
        rotate   = 1'b0;
        slip     = 1'b0;
        if (CE) begin
            case (state_q)
                // run is 0 in SEARCH, so a first match there lands on run=1 like any VERIFY match
                ST_SEARCH, ST_VERIFY: begin
                    if (match) begin
                        rotate = 1'b1;
                        run_d  = run_q + RUN_W'(1);
                        if (int'(run_q) + 1 >= LOCK_LEN) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        slip    = 1'b1;
                        run_d   = '0;
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    rotate = 1'b1;
                    if (match) begin
                        streak_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (ERR_COUNT != '1) errc_d = ERR_COUNT + ERR_W'(1);
                        if (int'(streak_q) + 1 >= UNLOCK_ERRS) begin
                            state_d  = ST_SEARCH;
                            streak_d = '0;
                            slip_d   = '0;
                        end else begin
                            streak_d = streak_q + STK_W'(1);
                        end
                    end
                end
                ST_FAIL: ;
            endcase
            if (slip) begin
                slip_d = SLIP_COUNT + SLIP_W'(1);
                if (int'(slip_d) >= MAX_SLIP) state_d = ST_FAIL;
            end
        end
    end

    // NOTE: the rings are ordinary flops rather than a RAM, so loading the seeds in reset is legitimate.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_SEARCH;
            ring1      <= SEED1;
            ring2      <= SEED2;
            ring3      <= SEED3;
            run_q      <= '0;
            streak_q   <= '0;
            LOCKED     <= 1'b0;
            ERROR      <= 1'b0;
            ERR_COUNT  <= '0;
            SLIP_COUNT <= '0;
            TIMEOUT    <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking updates so every flop samples pre-edge values.
            state_q    <= state_d;
            run_q      <= run_d;
            streak_q   <= streak_d;
            LOCKED     <= (state_d == ST_LOCKED);
            ERROR      <= error_d;
            ERR_COUNT  <= errc_d;
            SLIP_COUNT <= slip_d;
            TIMEOUT    <= (state_d == ST_FAIL);
            if (rotate) begin
                ring1 <= {ring1[0], ring1[254:1]};
                ring2 <= {ring2[0], ring2[255:1]};
                ring3 <= {ring3[0], ring3[256:1]};
            end
        end
    end

`ifdef PRBS_DDR_CHECKER_FIRST_ERR_EN
    logic [31:0] lock_cyc, cyc_next;

    // 1-based count of CE edges spent in LOCKED, saturating
    assign cyc_next = (lock_cyc == '1) ? lock_cyc : lock_cyc + 32'd1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lock_cyc      <= '0;
            FIRST_ERR_POS <= '0;
            FIRST_ERR_VLD <= 1'b0;
        end else if (CE && state_q == ST_LOCKED) begin
            if (state_d != ST_LOCKED) begin
                lock_cyc      <= '0;
                FIRST_ERR_POS <= '0;
                FIRST_ERR_VLD <= 1'b0;
            end else begin
                lock_cyc <= cyc_next;
                if (error_d && !FIRST_ERR_VLD) begin
                    FIRST_ERR_POS <= cyc_next;
                    FIRST_ERR_VLD <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_ddr_checker.sv
// Self-checking bench for prbs_ddr_checker: a position-indexed stimulus source, an optional delay
// line, and a behavioural checker model compared on every clock.
module tb_prbs_ddr_checker;

    localparam logic [254:0] S1 = 255'({64'h0123456789ABCDEF, 64'hF0E1D2C3B4A59687,
                                        64'h5A5AC3C33C3CA5A5, 64'h13579BDF2468ACE0});
    localparam logic [255:0] S2 = 256'({64'hCAFEBABEDEADBEEF, 64'h8BADF00D0DDBA11A,
                                        64'h1BADB002FEEDFACE, 64'h600DD00DB16B00B5});
    localparam logic [256:0] S3 = 257'({1'b0, 64'h7E57C0DE0BADC0DE, 64'hA5C3E1F09182736B,
                                        64'h2F4E6D8CABCAE9F8, 64'h0F1E2D3C4B5A6978});
    localparam int LOCK_LEN    = 16;
    localparam int UNLOCK_ERRS = 4;
    localparam int MAX_SLIP    = 64;
    localparam int ERR_W       = 4;
    localparam int SLIP_W      = $clog2(MAX_SLIP + 1);
    localparam int ERR_MAX     = (1 << ERR_W) - 1;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              CE = 1'b0;
    logic              D1 = 1'b0;
    logic              D2 = 1'b0;
    logic              LOCKED, ERROR, TIMEOUT;
    logic [ERR_W-1:0]  ERR_COUNT;
    logic [SLIP_W-1:0] SLIP_COUNT;
`ifdef PRBS_DDR_CHECKER_FIRST_ERR_EN
    logic [31:0]       first_err_pos;
    logic              first_err_vld;
`endif

    prbs_ddr_checker #(
        .SEED1(S1), .SEED2(S2), .SEED3(S3), .LOCK_LEN(LOCK_LEN),
        .UNLOCK_ERRS(UNLOCK_ERRS), .MAX_SLIP(MAX_SLIP), .ERR_W(ERR_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .D1(D1), .D2(D2),
        .LOCKED(LOCKED), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT),
        .SLIP_COUNT(SLIP_COUNT), .TIMEOUT(TIMEOUT)
`ifdef PRBS_DDR_CHECKER_FIRST_ERR_EN
        , .FIRST_ERR_POS(first_err_pos), .FIRST_ERR_VLD(first_err_vld)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int delay;
        int exp_slips;
        int budget;
    } dly_vec_t;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    logic [254:0] s1;
    logic [255:0] s2;
    logic [256:0] s3;
    int           gen_pos;
    logic [1:0]   pipe [0:15];
    int           delay;
    bit           force_zero;

    // Checker model: replica position, consecutive-match run, error streak, counters.
    int m_pos, m_run, m_streak, m_slips, m_errs;
    bit m_locked, m_error, m_timeout;

    // Source bit at CE-position p: ring rotation means bit0 after p steps is seed[p mod len].
    function automatic bit src1(input int p);
        return s1[p % 255] ^ s2[p % 256];
    endfunction

    function automatic bit src2(input int p);
        return s2[p % 256] ^ s3[p % 257];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit ce, input bit d1, input bit d2);
        bit m;
        if (!rst_n) begin
            m_pos = 0; m_run = 0; m_streak = 0; m_slips = 0; m_errs = 0;
            m_locked = 0; m_error = 0; m_timeout = 0;
            return;
        end
        m_error = 0;
        if (!ce || m_timeout) return;
        m = (d1 == src1(m_pos)) && (d2 == src2(m_pos));
        if (m_locked) begin
            m_pos++;
            if (m) begin
                m_streak = 0;
            end else begin
                m_error = 1;
                m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
                m_streak++;
                if (m_streak == UNLOCK_ERRS) begin
                    m_locked = 0; m_streak = 0; m_slips = 0; m_run = 0;
                end
            end
        end else if (m) begin
            m_pos++;
            m_run++;
            if (m_run == LOCK_LEN) begin
                m_locked = 1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
            m_slips++;
            if (m_slips == MAX_SLIP) m_timeout = 1;
        end
    endtask

    // One clock: drive source (optionally delayed/forced/corrupted), clock, then compare.
    task automatic step(input bit ce, input bit x1, input bit x2);
        logic [1:0] g, r;
        g = {src1(gen_pos), src2(gen_pos)};
        r = (delay == 0) ? g : pipe[delay-1];
        if (force_zero) r = 2'b00;
        CE = ce;
        D1 = r[1] ^ x1;
        D2 = r[0] ^ x2;
        @(posedge CLK);
        model_edge(RST_N, ce, D1, D2);
        if (!RST_N) begin
            gen_pos = 0;
            for (int i = 0; i < 16; i++) pipe[i] = 2'b00;
        end else if (ce) begin
            for (int i = 15; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = g;
            gen_pos++;
        end
        #1;
        cyc++;
        check("locked", 32'(LOCKED), 32'(m_locked));
        check("error", 32'(ERROR), 32'(m_error));
        check("err_count", 32'(ERR_COUNT), 32'(m_errs));
        check("slip_count", 32'(SLIP_COUNT), 32'(m_slips));
        check("timeout", 32'(TIMEOUT), 32'(m_timeout));
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        repeat (n) step(1'b1, 1'b0, 1'b0);
        RST_N = 1'b1;
    endtask

    task automatic run_until_locked(input int budget, input bit rnd_ce);
        for (int i = 0; i < budget && LOCKED !== 1'b1; i++)
            step(rnd_ce ? bit'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dly_vec_t dly_tab [5];
        int       pulses;
        bit       ce_r;
        int       c;

        s1 = S1; s2 = S2; s3 = S3;
        delay = 0; force_zero = 0; gen_pos = 0;
        for (int i = 0; i < 16; i++) pipe[i] = 2'b00;
        dly_tab = '{'{0, 0, 40}, '{1, 1, 60}, '{3, 3, 60}, '{5, 5, 80}, '{7, 7, 80}};

        // Reset values, then lock on exactly the 16th CE edge with a direct connection.
        do_reset(3);
        check("rst_locked", 32'(LOCKED), 32'd0);
        check("rst_err_count", 32'(ERR_COUNT), 32'd0);
        check("rst_slip_count", 32'(SLIP_COUNT), 32'd0);
        check("rst_timeout", 32'(TIMEOUT), 32'd0);
        repeat (15) step(1'b1, 1'b0, 1'b0);
        check("lock_edge15", 32'(LOCKED), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("lock_edge16", 32'(LOCKED), 32'd1);
        repeat (10000) step(1'b1, 1'b0, 1'b0);
        check("direct_locked", 32'(LOCKED), 32'd1);
        check("direct_slips", 32'(SLIP_COUNT), 32'd0);
        check("direct_errs", 32'(ERR_COUNT), 32'd0);

        // Path delay d needs exactly d slips, then no error pulses.
        for (int k = 0; k < 5; k++) begin
            delay = dly_tab[k].delay;
            do_reset(2);
            run_until_locked(dly_tab[k].budget, 1'b0);
            check("dly_locked", 32'(LOCKED), 32'd1);
            check("dly_slips", 32'(SLIP_COUNT), 32'(dly_tab[k].exp_slips));
            pulses = 0;
            repeat (64) begin
                step(1'b1, 1'b0, 1'b0);
                if (ERROR === 1'b1) pulses++;
            end
            check("dly_err_pulses", 32'(pulses), 32'd0);
        end
        delay = 0;

        // Single inverted D1 cycle: one ERROR pulse, lock held.
        do_reset(2);
        run_until_locked(40, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("inv1_error", 32'(ERROR), 32'd1);
        check("inv1_errs", 32'(ERR_COUNT), 32'd1);
        check("inv1_locked", 32'(LOCKED), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("inv1_error_drop", 32'(ERROR), 32'd0);
        check("inv1_locked_after", 32'(LOCKED), 32'd1);

        // Four consecutive D2 errors unlock; relock keeps ERR_COUNT.
        do_reset(2);
        run_until_locked(40, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        check("inv2_locked_3", 32'(LOCKED), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        check("inv2_errs", 32'(ERR_COUNT), 32'd4);
        check("inv2_unlocked", 32'(LOCKED), 32'd0);
        check("inv2_slips", 32'(SLIP_COUNT), 32'd0);
        repeat (15) step(1'b1, 1'b0, 1'b0);
        check("relock_15", 32'(LOCKED), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("relock_16", 32'(LOCKED), 32'd1);
        check("relock_errs", 32'(ERR_COUNT), 32'd4);

        // A good cycle clears the streak; isolated errors saturate the count.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        check("streak_locked", 32'(LOCKED), 32'd1);
        check("streak_errs", 32'(ERR_COUNT), 32'd10);
        step(1'b1, 1'b0, 1'b0);
        repeat (10) begin
            step(1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        check("sat_errs", 32'(ERR_COUNT), 32'(ERR_MAX));
        check("sat_locked", 32'(LOCKED), 32'd1);

        // Constant zero input exhausts the search; TIMEOUT is sticky.
        force_zero = 1;
        do_reset(2);
        for (int i = 0; i < 1000 && TIMEOUT !== 1'b1; i++) step(1'b1, 1'b0, 1'b0);
        check("to_timeout", 32'(TIMEOUT), 32'd1);
        check("to_slips", 32'(SLIP_COUNT), 32'(MAX_SLIP));
        check("to_locked", 32'(LOCKED), 32'd0);
        repeat (1000) step(1'b1, 1'b0, 1'b0);
        check("to_sticky", 32'(TIMEOUT), 32'd1);
        check("to_slips_hold", 32'(SLIP_COUNT), 32'(MAX_SLIP));
        force_zero = 0;

        // Shared random CE, then a one-cycle reset while locked.
        do_reset(2);
        run_until_locked(400, 1'b1);
        check("rce_locked", 32'(LOCKED), 32'd1);
        check("rce_errs", 32'(ERR_COUNT), 32'd0);
        repeat (50) step(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
        RST_N = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check("mid_rst_locked", 32'(LOCKED), 32'd0);
        check("mid_rst_error", 32'(ERROR), 32'd0);
        check("mid_rst_errs", 32'(ERR_COUNT), 32'd0);
        check("mid_rst_slips", 32'(SLIP_COUNT), 32'd0);
        check("mid_rst_timeout", 32'(TIMEOUT), 32'd0);
        RST_N = 1'b1;
        run_until_locked(400, 1'b1);
        check("rce_relock", 32'(LOCKED), 32'd1);

        // Random soak: random delay and CE, sparse corruption while the model is locked.
        for (int blk = 0; blk < 8; blk++) begin
            delay = $urandom_range(0, 4);
            do_reset(2);
            repeat (500) begin
                ce_r = ($urandom_range(0, 3) != 0);
                if (m_locked && $urandom_range(0, 9) == 0) begin
                    c = $urandom_range(1, 3);
                    step(ce_r, c[1], c[0]);
                end else begin
                    step(ce_r, 1'b0, 1'b0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
